// File: rtl/example_pair_pkg.sv
// rtl/example_pair_pkg.sv - shared types and pair-code constants for the pair receiver
// Purpose: FSM state encoding and the two legal complementary-pair codes.
// Ports: none (package).
package example_pair_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_DATA = 1'b1
  } pair_state_e;

  // {y, z} as sampled from the line
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

endpackage

// File: rtl/example_pair_rx_if.sv
// rtl/example_pair_rx_if.sv - word output handshake between receiver and consumer
// Purpose: carries the deserialised word with a valid/ready handshake.
// Ports (signals):
//   out_data  [WIDTH]  received word, held while out_valid && !out_ready
//   out_valid          word available
//   out_ready          consumer takes the word when out_valid && out_ready
// Modports: master = receiver (drives data/valid), slave = consumer (drives ready).
interface example_pair_rx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/example_pair_sampler.sv
// rtl/example_pair_sampler.sv - line sample flops and pair-code classification
// Purpose: registers the raw pair once and classifies the registered code.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   y_i, z_i   raw pair lines
//   smp_vld_o  a real sample has been captured since reset
//   bit_val_o  decoded bit (the y line; also the value used for invalid codes)
//   bit_ok_o   registered code is a legal pair (10 or 01)
module example_pair_sampler
  import example_pair_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic y_i,
  input  logic z_i,
  output logic smp_vld_o,
  output logic bit_val_o,
  output logic bit_ok_o
);

  logic [1:0] code_q;
  logic       vld_q;

  // The cleared sample flops hold 2'b00, which would classify as invalid;
  // vld_q keeps that reset artefact from reaching the error counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q <= 2'b00;
      vld_q  <= 1'b0;
    end else begin
      code_q <= {y_i, z_i};
      vld_q  <= 1'b1;
    end
  end

  assign smp_vld_o = vld_q;
  assign bit_val_o = code_q[1];
  assign bit_ok_o  = (code_q == PAIR_ONE) || (code_q == PAIR_ZERO);

endmodule

// File: rtl/example_pair_rx.sv
// rtl/example_pair_rx.sv - complementary-pair serial receiver with sync hunt
// Purpose: hunts for SYNC_PAT, then deserialises back-to-back WIDTH-bit words
//   MSB-first onto a one-entry valid/ready output register.
// Ports:
//   tukli     clock, rising edge
//   rst       synchronous active-high reset
//   in_y/in_z pair lines (10 = one, 01 = zero, else invalid)
//   out_if    master side of the word handshake (out_data/out_valid/out_ready)
//   lock      high while in DATA
//   err_cnt   saturating count of invalid pair codes
//   overflow  sticky: a completed word was dropped
// WIDTH and SYNC_LEN must be >= 2, ERR_LIMIT >= 1.
module example_pair_rx
  import example_pair_pkg::*;
#(
  parameter int                  WIDTH     = 8,
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT  = 8'hA5,
  parameter int                  ERR_LIMIT = 3
) (
  input  logic                    tukli,
  input  logic                    rst,
  input  logic                    in_y,
  input  logic                    in_z,
  example_pair_rx_if.master       out_if,
  output logic                    lock,
  output logic [7:0]              err_cnt,
  output logic                    overflow
);

  localparam int SCW = $clog2(SYNC_LEN + 1);
  localparam int BCW = $clog2(WIDTH);
  localparam int ECW = $clog2(ERR_LIMIT + 1);
  localparam logic [SCW-1:0] SYNC_FULL = SCW'(SYNC_LEN);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WIDTH - 1);
  localparam logic [ECW-1:0] ERR_MAX   = ECW'(ERR_LIMIT);

  logic smp_vld, bit_val, bit_ok;

  example_pair_sampler u_sampler (
    .clk_i     (tukli),
    .rst_i     (rst),
    .y_i       (in_y),
    .z_i       (in_z),
    .smp_vld_o (smp_vld),
    .bit_val_o (bit_val),
    .bit_ok_o  (bit_ok)
  );

  pair_state_e         state_q, state_d;
  logic [SYNC_LEN-1:0] win_q, win_d;
  logic [SCW-1:0]      scnt_q, scnt_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [ECW-1:0]      ecnt_q, ecnt_d;
  logic [7:0]          err_q, err_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                done;

  always_ff @(posedge tukli) begin
    if (rst) begin
      state_q <= ST_HUNT;
      win_q   <= '0;
      scnt_q  <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      ecnt_q  <= '0;
      err_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      scnt_q  <= scnt_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      ecnt_q  <= ecnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    scnt_d  = scnt_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    ecnt_d  = ecnt_q;
    err_d   = err_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    done    = 1'b0;

    if (valid_q && out_if.out_ready) valid_d = 1'b0;
    if (smp_vld && !bit_ok && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    if (smp_vld) begin
      case (state_q)
        ST_HUNT: begin
          if (bit_ok) begin
            win_d = {win_q[SYNC_LEN-2:0], bit_val};
            if (scnt_q != SYNC_FULL) scnt_d = scnt_q + 1'b1;
            // Count and window both include the bit arriving on this edge.
            if ((scnt_d == SYNC_FULL) && (win_d == SYNC_PAT)) begin
              state_d = ST_DATA;
              bcnt_d  = '0;
              ecnt_d  = '0;
            end
          end else begin
            scnt_d = '0;
          end
        end
        ST_DATA: begin
          // Invalid codes still occupy a bit slot, carrying the y value.
          word_d = {word_q[WIDTH-2:0], bit_val};
          ecnt_d = bit_ok ? '0 : ecnt_q + 1'b1;
          bcnt_d = (bcnt_q == LAST_BIT) ? '0 : bcnt_q + 1'b1;
          // Lock loss takes priority over a word completing on the same bit.
          if (ecnt_d == ERR_MAX) begin
            state_d = ST_HUNT;
            scnt_d  = '0;
            bcnt_d  = '0;
            ecnt_d  = '0;
            word_d  = '0;
          end else if (bcnt_q == LAST_BIT) begin
            done = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (done) begin
      if (valid_q && !out_if.out_ready) begin
        ovf_d = 1'b1;
      end else begin
        data_d  = word_d;
        valid_d = 1'b1;
      end
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign lock             = (state_q == ST_DATA);
  assign err_cnt          = err_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_example_pair_rx.sv
// tb/tb_example_pair_rx.sv - self-checking bench for example_pair_rx
module tb_example_pair_rx;

  logic       tukli = 1'b0;
  logic       rst   = 1'b1;
  logic       in_y  = 1'b0;
  logic       in_z  = 1'b1;
  logic       lock;
  logic       overflow;
  logic [7:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  example_pair_rx_if #(.WIDTH(8)) oif ();

  example_pair_rx #(
    .WIDTH(8), .SYNC_LEN(8), .SYNC_PAT(8'hA5), .ERR_LIMIT(3)
  ) dut (
    .tukli    (tukli),
    .rst      (rst),
    .in_y     (in_y),
    .in_z     (in_z),
    .out_if   (oif),
    .lock     (lock),
    .err_cnt  (err_cnt),
    .overflow (overflow)
  );

  always #5 tukli = ~tukli;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] qval(input bit q[$]);
    logic [7:0] v = 8'h00;
    foreach (q[i]) v = {v[6:0], q[i]};
    return v;
  endfunction

  // Behavioural model: a pair on the pins is acted upon one edge after it is sampled.
  bit         m_sv;
  logic [1:0] m_sc;
  bit         m_lock;
  int         m_vrun;
  bit         m_hist[$];
  bit         m_word[$];
  int         m_inv;
  int         m_err;
  bit         m_ovf;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_acc, m_nov, m_good, m_b;

  always @(posedge tukli) begin
    if (rst) begin
      m_sv = 0; m_lock = 0; m_vrun = 0; m_inv = 0; m_err = 0;
      m_ovf = 0; m_ov = 0; m_od = 8'h00;
      m_hist.delete(); m_word.delete();
    end else begin
      m_acc = m_ov && oif.out_ready;
      m_nov = m_ov && !m_acc;
      if (m_sv) begin
        m_good = (m_sc == 2'b10) || (m_sc == 2'b01);
        m_b    = m_sc[1];
        if (!m_good && m_err < 255) m_err++;
        if (!m_lock) begin
          if (m_good) begin
            m_vrun++;
            m_hist.push_back(m_b);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            if (m_vrun >= 8 && qval(m_hist) == 8'hA5) begin
              m_lock = 1; m_inv = 0; m_word.delete();
            end
          end else begin
            m_vrun = 0;
          end
        end else begin
          m_word.push_back(m_b);
          m_inv = m_good ? 0 : m_inv + 1;
          if (m_inv == 3) begin
            m_lock = 0; m_vrun = 0; m_inv = 0; m_word.delete();
          end else if (m_word.size() == 8) begin
            if (m_nov) m_ovf = 1;
            else begin m_od = qval(m_word); m_nov = 1; end
            m_word.delete();
          end
        end
      end
      m_ov = m_nov;
      m_sv = 1;
      m_sc = {in_y, in_z};
    end
  end

  always @(negedge tukli) begin
    chk("lock", lock, m_lock);
    chk("err_cnt", err_cnt, m_err);
    chk("overflow", overflow, m_ovf);
    chk("out_valid", oif.out_valid, m_ov);
    if (m_ov) chk("out_data", oif.out_data, m_od);
  end

  logic [7:0] got[$];
  always @(negedge tukli) begin
    if (!rst && oif.out_valid && oif.out_ready) got.push_back(oif.out_data);
  end

  task automatic put(input logic [1:0] c);
    {in_y, in_z} = c;
    @(posedge tukli);
    #1;
  endtask

  task automatic put_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) put(v[i] ? 2'b10 : 2'b01);
  endtask

  task automatic drop_lock();
    repeat (3) put(2'b00);
    put(2'b01);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    put(2'b01);
    put(2'b01);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    oif.out_ready = 1'b0;
    do_reset();
    chk("rst_valid", oif.out_valid, 0);
    chk("rst_data", oif.out_data, 8'h00);
    chk("rst_lock", lock, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ovf", overflow, 0);

    // sync then 8'h3C
    put_bits(8'hA5);
    chk("t1_prelock", lock, 0);
    put(2'b01);
    chk("t1_lock", lock, 1);
    pat = 8'h3C;
    for (int i = 6; i >= 0; i--) put(pat[i] ? 2'b10 : 2'b01);
    chk("t1_valid_e0", oif.out_valid, 0);
    put(2'b01);
    chk("t1_valid_e1", oif.out_valid, 1);
    chk("t1_data", oif.out_data, 8'h3C);
    chk("t1_err", err_cnt, 0);
    oif.out_ready = 1'b1;

    // three consecutive invalid codes drop lock
    put(2'b00); put(2'b00);
    chk("t4_lock_held", lock, 1);
    put(2'b00);
    chk("t4_lock_edge", lock, 1);
    put(2'b01);
    chk("t4_lock_lost", lock, 0);
    chk("t4_err", err_cnt, 3);

    // corrupted sync then clean sync
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) put((i == 4) ? 2'b11 : (pat[i] ? 2'b10 : 2'b01));
    put_bits(8'hA5);
    chk("t2_err", err_cnt, 4);
    chk("t2_nolock", lock, 0);

    // overflow with out_ready low
    oif.out_ready = 1'b0;
    put_bits(8'h11);
    chk("t2_lock", lock, 1);
    put_bits(8'h22);
    put(2'b01); put(2'b01);
    chk("t3_hold", oif.out_data, 8'h11);
    chk("t3_ovf", overflow, 1);
    oif.out_ready = 1'b1;
    put(2'b01);

    // same words with ready always high
    do_reset();
    put_bits(8'hA5);
    got.delete();
    put_bits(8'h11);
    put_bits(8'h22);
    put(2'b01); put(2'b01); put(2'b01);
    chk("t3b_cnt", got.size(), 2);
    if (got.size() >= 2) begin
      chk("t3b_w0", got[0], 8'h11);
      chk("t3b_w1", got[1], 8'h22);
    end
    chk("t3b_ovf", overflow, 0);

    // two invalid codes then valid: word keeps y=0 at those bits;
    // then lock loss on the last bit of a word discards it
    drop_lock();
    put_bits(8'hA5);
    got.delete();
    put(2'b10); put(2'b10); put(2'b00); put(2'b00);
    put(2'b10); put(2'b10); put(2'b10); put(2'b10);
    repeat (5) put(2'b10);
    repeat (3) put(2'b00);
    put(2'b01); put(2'b01); put(2'b01);
    chk("t4b_lock", lock, 0);
    chk("t4b_cnt", got.size(), 1);
    if (got.size() >= 1) chk("t4b_word", got[0], 8'hCF);

    // reset mid-word with a held word
    do_reset();
    oif.out_ready = 1'b0;
    put_bits(8'hA5);
    put_bits(8'h5A);
    put(2'b10);
    chk("t5_valid", oif.out_valid, 1);
    put(2'b01); put(2'b10);
    rst = 1'b1;
    put(2'b01);
    rst = 1'b0;
    chk("t5_valid_rst", oif.out_valid, 0);
    chk("t5_data_rst", oif.out_data, 8'h00);
    chk("t5_lock_rst", lock, 0);
    chk("t5_err_rst", err_cnt, 0);
    oif.out_ready = 1'b1;
    put_bits(8'h3C); put_bits(8'h3C);
    chk("t5_nolock", lock, 0);
    chk("t5_novalid", oif.out_valid, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      oif.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) put_bits(8'hA5);
      else if ($urandom_range(0, 99) < 5) put($urandom_range(0, 1) ? 2'b11 : 2'b00);
      else put($urandom_range(0, 1) ? 2'b10 : 2'b01);
    end

    // saturation
    repeat (300) put(2'b11);
    put(2'b01);
    chk("t6_sat", err_cnt, 8'hFF);

    put(2'b01); put(2'b01);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
